uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from four requesters into one UART TX serializer.
// Define UART_ARB_PRIORITY_EN to make requester 0 always win over the round-robin pool.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               tx_start_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_busy_i,
  output logic [1:0]         cur_id_o,
  output logic               arb_busy_o,
  output logic               err_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [1:0]         cur_id_q, cur_id_d;
  logic [1:0]         last_q, last_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               win_valid;
  logic [1:0]         win_id;
  logic [1:0]         cand;
  logic               launch;
  logic               timeout;

  // Search starts just past the last winner, so a requester that keeps REQ high
  // after its grant goes to the back of the queue.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_q + 2'(k);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
`ifdef UART_ARB_PRIORITY_EN
    if (req_i[0]) begin
      win_valid = 1'b1;
      win_id    = 2'd0;
    end
`endif
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign launch  = (state_q == IDLE) && !tx_busy_i && win_valid;
  assign timeout = (state_q == WAIT_ACK) && !tx_busy_i && (cnt_inc == CNT_W'(ACK_TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      cur_id_q   <= 2'd0;
      last_q     <= 2'd3;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cur_id_q   <= cur_id_d;
      last_q     <= last_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (launch) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy_i)    state_d = WAIT_DONE;
        else if (timeout) state_d = IDLE;
      end
      WAIT_DONE: if (!tx_busy_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A timed-out byte is dropped; LAST keeps the dropped winner so it is not retried first.
  always_comb begin
    gnt_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    cur_id_d   = cur_id_q;
    last_d     = last_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    if (launch) begin
      gnt_d[win_id] = 1'b1;
      tx_start_d    = 1'b1;
      tx_data_d     = req_data_i[{win_id, 3'b000} +: 8];
      cur_id_d      = win_id;
      last_d        = win_id;
      cnt_d         = '0;
    end else if (state_q == WAIT_ACK) begin
      cnt_d = cnt_inc;
      err_d = timeout;
    end
  end

  assign gnt_o      = gnt_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign cur_id_o   = cur_id_q;
  assign arb_busy_o = (state_q != IDLE);
  assign err_o      = err_q;

endmodule
